// File: rtl/i2s_pkg.sv
// Shared types and limits for the parametrised I2S master transmitter.
package i2s_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } i2s_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } tx_state_e;

  localparam int I2S_MAX_SLOT_W = 64;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding {left, right} sample pairs.
module i2s_tx_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop & ~empty;
  // A pop frees its slot in the same cycle, so a push against a full FIFO still lands.
  assign ready = ~full | rd_en;
  assign wr_en = push & ready;
  assign rdata = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/i2s_tx_mc.sv
// I2S / left-justified master transmitter with bit-clock divider and sample FIFO.
// Optional `I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module i2s_tx_mc
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            clk_div,
  input  i2s_mode_e                   mode,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_left,
  input  logic [DATA_W-1:0]           s_right,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        frame_start,
  output logic                        underrun,
  output logic                        tclk,
  output logic                        ws,
  output logic                        td
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int              FRAME_W = 2 * SLOT_W;
  localparam int              B_W     = $clog2(FRAME_W);
  localparam logic [B_W-1:0]  B_LAST  = B_W'(FRAME_W - 1);
  localparam logic [B_W-1:0]  SLOT_B  = B_W'(SLOT_W);

  tx_state_e            state;
  i2s_mode_e            mode_q;
  logic [DIV_W-1:0]     clk_div_q;
  logic [DIV_W-1:0]     div_cnt;
  logic [B_W-1:0]       b;
  logic [FRAME_W-1:0]   shift;
  logic [FRAME_W-1:0]   load_word;
  logic [2*DATA_W-1:0]  fifo_rdata;
  logic                 fifo_empty;
  logic                 tc, fall, rise, frame_edge, pop, ws_next;
  logic [B_W-1:0]       b_next, b_lead;

  i2s_tx_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata ({s_left, s_right}),
    .ready (s_ready),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign busy       = (state != IDLE);
  assign tc         = busy && (div_cnt == clk_div_q);
  assign fall       = tc & tclk;
  assign rise       = tc & ~tclk;
  assign b_next     = (b == B_LAST) ? '0 : b + 1'b1;
  assign b_lead     = (b_next == B_LAST) ? '0 : b_next + 1'b1;
  assign frame_edge = fall && (b == B_LAST);
  assign pop        = frame_edge & ~fifo_empty;
  // I2S moves word select one bit ahead of the data it frames.
  assign ws_next    = (mode_q == MODE_LJ) ? (b_next >= SLOT_B) : (b_lead >= SLOT_B);

  always_comb begin
    // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
    load_word = '0;
    if (!fifo_empty)
      load_word = (FRAME_W'(fifo_rdata[2*DATA_W-1:DATA_W]) << (FRAME_W - DATA_W))
                | (FRAME_W'(fifo_rdata[DATA_W-1:0])        << (SLOT_W - DATA_W));
  end

  // NOTE: every state update is non-blocking, so all branches below see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_I2S;
      clk_div_q   <= '0;
      div_cnt     <= '0;
      b           <= B_LAST;
      shift       <= '0;
      tclk        <= 1'b1;
      ws          <= 1'b1;
      td          <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: begin
          mode_q    <= mode;
          clk_div_q <= clk_div;
          div_cnt   <= '0;
          b         <= B_LAST;
          if (enable) state <= RUN;
        end
        RUN, STOP: begin
          div_cnt <= tc ? '0 : div_cnt + 1'b1;
          if (tc) tclk <= ~tclk;
          if (fall) begin
            b  <= b_next;
            ws <= ws_next;
            if (frame_edge) begin
              frame_start <= 1'b1;
              underrun    <= fifo_empty;
              shift       <= load_word;
              td          <= load_word[FRAME_W-1];
            end else begin
              shift <= shift << 1;
              td    <= shift[FRAME_W-2];
            end
          end
          if (state == RUN) begin
            if (!enable) state <= STOP;
          end else if (enable) begin
            state <= RUN;
          end else if (rise && (b == B_LAST)) begin
            // Last bit has had its rising edge: park the lines and go idle.
            state   <= IDLE;
            ws      <= 1'b1;
            td      <= 1'b0;
            div_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underrun_cnt <= '0;
    else if (underrun && (underrun_cnt != 16'hFFFF))
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx_mc.sv
// Self-checking bench for i2s_tx_mc: directed framing cases plus randomized runs
// checked cycle by cycle against an arithmetic model of the wire timing.
module tb_i2s_tx_mc;
  import i2s_pkg::*;

  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 8;
  localparam int FRAME_W    = 2 * SLOT_W;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, enable, s_valid, s_ready;
  logic              busy, frame_start, underrun, tclk, ws, td;
  logic [DIV_W-1:0]  clk_div;
  i2s_mode_e         mode;
  logic [DATA_W-1:0] s_left, s_right;
  logic [LW-1:0]     fifo_level;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  i2s_tx_mc #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_div(clk_div), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .fifo_level(fifo_level), .busy(busy), .frame_start(frame_start),
    .underrun(underrun), .tclk(tclk), .ws(ws), .td(td)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: time since start, sample queue, and current frame samples.
  logic [2*DATA_W-1:0] q[$];
  bit                  m_run, m_stop, m_tclk, m_ws, m_td, ev_start, ev_under;
  int                  m_t, m_d, m_b, m_nframes, m_ucnt;
  i2s_mode_e           m_mode;
  logic [DATA_W-1:0]   m_left, m_right;

  logic [63:0] cap_td, cap_ws;
  int          n_rise;
  bit          prev_tclk, pre_td, pre_ws;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_td(input int bidx);
    int k = bidx % SLOT_W;
    logic [DATA_W-1:0] smp = (bidx >= SLOT_W) ? m_right : m_left;
    if (k >= DATA_W) return 1'b0;
    return smp[DATA_W-1-k];
  endfunction

  function automatic bit pop_next();
    int t1 = m_t + 1;
    int tog;
    if (!m_run || q.size() == 0 || (t1 % (m_d + 1)) != 0) return 1'b0;
    tog = t1 / (m_d + 1);
    return (tog % 2 == 1) && ((((tog + 1) / 2 - 1) % FRAME_W) == 0);
  endfunction

  function automatic logic [63:0] pins_dut();
    return 64'({tclk, ws, td, busy, frame_start, underrun, s_ready, fifo_level});
  endfunction

  function automatic logic [63:0] pins_exp();
    bit rdy = (q.size() < FIFO_DEPTH) || pop_next();
    return 64'({m_tclk, m_ws, m_td, m_run, ev_start, ev_under, rdy, LW'(q.size())});
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0; m_stop = 0; m_tclk = 1; m_ws = 1; m_td = 0;
    ev_start = 0; ev_under = 0; m_t = 0; m_b = 0; m_nframes = 0; m_ucnt = 0;
    m_left = '0; m_right = '0; prev_tclk = 1;
  endtask

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic model_edge();
    int sz0 = q.size();
    bit popped = 0;
    int tog;
    logic [2*DATA_W-1:0] pair;
    ev_start = 0;
    ev_under = 0;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_t = 0; m_d = int'(clk_div); m_mode = mode; m_stop = 0; m_nframes = 0;
      end
    end else begin
      m_t++;
      if (m_t % (m_d + 1) == 0) begin
        tog = m_t / (m_d + 1);
        if (tog % 2 == 1) begin
          m_b = ((tog + 1) / 2 - 1) % FRAME_W;
          if (m_b == 0) begin
            ev_start = 1;
            m_nframes++;
            if (sz0 > 0) begin
              pair = q.pop_front();
              popped = 1;
              m_left = pair[2*DATA_W-1:DATA_W];
              m_right = pair[DATA_W-1:0];
            end else begin
              m_left = '0; m_right = '0; ev_under = 1;
              if (m_ucnt != 65535) m_ucnt++;
            end
          end
          m_tclk = 0;
          m_td   = model_td(m_b);
          m_ws   = (m_mode == MODE_LJ) ? (m_b >= SLOT_W) : (((m_b + 1) % FRAME_W) >= SLOT_W);
        end else begin
          m_tclk = 1;
          if (m_stop && !enable && m_b == FRAME_W - 1) begin
            m_run = 0; m_ws = 1; m_td = 0;
          end
        end
      end
      if (m_run) m_stop = !enable;
    end
    if (s_valid && (sz0 < FIFO_DEPTH || popped)) q.push_back({s_left, s_right});
  endtask

  task automatic step();
    pre_td = td;
    pre_ws = ws;
    @(posedge clk);
    if (!rst) model_edge();
    else begin ev_start = 0; ev_under = 0; end
    #1;
    if (!prev_tclk && tclk) begin
      cap_td = {cap_td[62:0], pre_td};
      cap_ws = {cap_ws[62:0], pre_ws};
      n_rise++;
    end
    prev_tclk = tclk;
    check("pins", pins_dut(), pins_exp());
  endtask

  task automatic clear_cap();
    cap_td = '0; cap_ws = '0; n_rise = 0;
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    s_valid = 1; s_left = l; s_right = r;
    step();
    s_valid = 0;
  endtask

  task automatic wait_bit(input int frame, input int bit_idx, input int budget);
    int n = 0;
    while (!(m_run && m_nframes == frame && m_b == bit_idx) && n < budget) begin
      step();
      n++;
    end
    check("wait_bit", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    enable = 0;
    s_valid = 0;
    while (m_run && n < budget) begin
      step();
      n++;
    end
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_lines", 64'({tclk, ws, td}), 64'b110);
  endtask

  task automatic async_reset();
    #2;
    rst = 1; enable = 0; s_valid = 0;
    model_reset();
    #1;
    check("rst_pins", pins_dut(), pins_exp());
    step();
    step();
    rst = 0;
  endtask

  initial begin
    int len, pre, pct;
    rst = 1; enable = 0; s_valid = 0; s_left = '0; s_right = '0;
    clk_div = '0; mode = MODE_I2S;
    model_reset();
    clear_cap();
    repeat (3) step();
    check("rst_ready", 64'(s_ready), 64'd1);
    rst = 0;
    step();

    // LJ framing, divider 1: MSB-aligned samples, ws low for left slot.
    clk_div = 8'd1; mode = MODE_LJ;
    push_pair(24'hA5A5A5, 24'h3C3C3C);
    clear_cap();
    enable = 1;
    wait_bit(1, 40, 2000);
    wait_idle(2000);
    check("t1_rises", 64'(n_rise), 64'd64);
    check("t1_td", cap_td, 64'hA5A5A5003C3C3C00);
    check("t1_ws", cap_ws, 64'h00000000FFFFFFFF);

    // I2S framing: ws leads each slot's MSB by one bit.
    clk_div = 8'd0; mode = MODE_I2S;
    push_pair(24'hA5A5A5, 24'h3C3C3C);
    clear_cap();
    enable = 1;
    wait_bit(1, 40, 2000);
    wait_idle(2000);
    check("t2_td", cap_td, 64'hA5A5A5003C3C3C00);
    check("t2_ws", cap_ws, 64'h00000001FFFFFFFE);

    // Overfill while idle, then drain one pair per frame; stop mid-frame.
    for (int i = 0; i < 5; i++) begin
      push_pair(DATA_W'($urandom), DATA_W'($urandom));
      if (i == 3) check("t4_ready_full", 64'(s_ready), 64'd0);
    end
    check("t4_level", 64'(fifo_level), 64'd4);
    clk_div = 8'd2; mode = MODE_I2S;
    enable = 1;
    wait_bit(4, 10, 5000);
    wait_idle(2000);
    check("t4_level_end", 64'(fifo_level), 64'd0);

    // Empty FIFO: underrun frames, then a mid-frame push fills the next frame.
    clk_div = 8'd1; mode = MODE_LJ;
    enable = 1;
    wait_bit(1, 20, 2000);
    push_pair(24'h123456, 24'hFEDCBA);
    wait_bit(3, 5, 3000);
    wait_idle(2000);

    // Randomized runs: divider, mode, fill rate, enable blips, ignored config changes.
    for (int r = 0; r < 6; r++) begin
      clk_div = DIV_W'($urandom_range(0, 3));
      mode    = i2s_mode_e'($urandom_range(0, 1));
      pre     = $urandom_range(0, 4);
      pct     = $urandom_range(0, 5);
      for (int i = 0; i < pre; i++) push_pair(DATA_W'($urandom), DATA_W'($urandom));
      enable = 1;
      len = $urandom_range(300, 1500);
      for (int c = 0; c < len; c++) begin
        s_valid = ($urandom_range(0, 99) < pct);
        s_left  = DATA_W'($urandom);
        s_right = DATA_W'($urandom);
        if ($urandom_range(0, 199) == 0) begin
          clk_div = DIV_W'($urandom_range(0, 3));
          mode    = i2s_mode_e'($urandom_range(0, 1));
        end
        enable = ($urandom_range(0, 99) != 0);
        step();
      end
      wait_idle(3000);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("ucnt_rand", 64'(underrun_cnt), 64'(m_ucnt));
`endif
    end

    // Reset in the middle of the right slot, then count empty frames.
    clk_div = 8'd0; mode = MODE_LJ;
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    push_pair(24'h55AA55, 24'hAA55AA);
    enable = 1;
    wait_bit(1, 40, 2000);
    async_reset();
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_lines", 64'({tclk, ws, td, busy}), 64'b1100);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t6_ucnt_rst", 64'(underrun_cnt), 64'd0);
`endif
    enable = 1;
    wait_bit(3, 5, 2000);
    wait_idle(2000);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("t6_ucnt3", 64'(underrun_cnt), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
